thermal_tx_framer: RTL

//   Upstream stage of the thermal covert-channel transmitter. Accepts one byte per frame

---
 rtl/thermal_tx_framer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/thermal_tx_framer.sv
// Thermal covert-channel framer: serialises one byte per frame as on-off keying on heat_en.
// Frame = preamble, data MSB-first, even parity, then a forced-cool guard interval.
module thermal_tx_framer #(
    parameter int unsigned BIT_PERIOD = 50_000_000,
    parameter int unsigned PRE_BITS   = 4,
    parameter logic [7:0]  PREAMBLE   = 8'hA0,
    parameter int unsigned COOL_BITS  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic       heat_en,
    output logic       busy,
    output logic [3:0] bit_index,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAR,
        S_COOL
    } state_t;

    localparam logic [31:0] LAST_CNT  = 32'(BIT_PERIOD - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOL_BITS - 1);
    localparam logic [3:0]  PRE_LAST  = 4'(PRE_BITS - 1);
    localparam logic [3:0]  DATA_LAST = 4'(PRE_BITS + 7);
    localparam logic [3:0]  GUARD_IDX = 4'(PRE_BITS + 8);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cool_cnt_q, cool_cnt_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  pre_q, pre_d;
    logic        par_q, par_d;
    logic        heat_q, heat_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        bit_tc;

    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign heat_en    = heat_q;
    assign bit_index  = idx_q;
    assign frame_done = done_q;
    assign bit_tc     = (cnt_q == LAST_CNT);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cool_cnt_d = cool_cnt_q;
        data_d     = data_q;
        pre_d      = pre_q;
        par_d      = par_q;
        heat_d     = heat_q;
        idx_d      = idx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d = S_PRE;
                    data_d  = tx_data;
                    par_d   = ^tx_data;
                    pre_d   = {PREAMBLE[6:0], 1'b0};
                    heat_d  = PREAMBLE[7];
                    idx_d   = 4'd0;
                    cnt_d   = 32'd0;
                end
            end
            S_PRE, S_DATA, S_PAR: begin
                if (abort || (state_q == S_PAR && bit_tc)) begin
                    // Abort and normal parity exit both enter the guard interval from its start.
                    cnt_d      = 32'd0;
                    cool_cnt_d = 32'd0;
                    heat_d     = 1'b0;
                    if (COOL_BITS == 0) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_COOL;
                        idx_d   = GUARD_IDX;
                    end
                end else if (bit_tc) begin
                    cnt_d = 32'd0;
                    idx_d = idx_q + 4'd1;
                    if (state_q == S_PRE && idx_q != PRE_LAST) begin
                        heat_d = pre_q[7];
                        pre_d  = {pre_q[6:0], 1'b0};
                    end else if (idx_q == DATA_LAST) begin
                        state_d = S_PAR;
                        heat_d  = par_q;
                    end else begin
                        state_d = S_DATA;
                        heat_d  = data_q[7];
                        data_d  = {data_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_COOL: begin
                if (bit_tc) begin
                    cnt_d = 32'd0;
                    if (cool_cnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        cool_cnt_d = cool_cnt_q + 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                heat_d  = 1'b0;
                idx_d   = 4'd0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            cool_cnt_q <= 32'd0;
            data_q     <= 8'd0;
            pre_q      <= 8'd0;
            par_q      <= 1'b0;
            heat_q     <= 1'b0;
            idx_q      <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cool_cnt_q <= cool_cnt_d;
            data_q     <= data_d;
            pre_q      <= pre_d;
            par_q      <= par_d;
            heat_q     <= heat_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

endmodule
